// File: rtl/pixel_feeder_pkg.sv
// Shared FSM state type and default frame geometry for the pixel feeder
// and the convolution top it feeds.
package pixel_feeder_pkg;

    localparam int IMG_W_DEF  = 28;
    localparam int IMG_H_DEF  = 28;
    localparam int DATA_W_DEF = 8;

    localparam logic [2:0] PAT_FIRST = 3'd1;
    localparam logic [2:0] PAT_LAST  = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FETCH  = 2'd1,
        ST_STREAM = 2'd2,
        ST_DONE   = 2'd3
    } feeder_state_e;

    // Test pattern runs 1..5 and wraps back to 1.
    function automatic logic [2:0] next_pat(input logic [2:0] cur);
        if (cur == PAT_LAST) begin
            next_pat = PAT_FIRST;
        end else begin
            next_pat = cur + 3'd1;
        end
    endfunction

endpackage

// File: rtl/pixel_feeder_frame_ram.sv
// Frame buffer: one write port, one read port, registered read data
// (1-cycle latency). Contents are deliberately not reset.
module feeder_frame_ram #(
    parameter int DEPTH = 784,
    parameter int AW    = 10,
    parameter int DW    = 8
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic          re_i,
    input  logic [AW-1:0] raddr_i,
    output logic [DW-1:0] rdata_o
);

    logic [DW-1:0] mem_q [DEPTH];
    logic [DW-1:0] rdata_q;

    // Write port.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Read port, data valid the cycle after re_i.
    always_ff @(posedge clk) begin
        if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/pixel_feeder.sv
// Streams a stored frame in raster order over a valid/ready link with sof/eol/eof.
// Optional test pattern source enabled by macro PIXEL_FEEDER_TESTPAT_EN.
module pixel_feeder
    import pixel_feeder_pkg::*;
#(
    parameter int IMG_W  = IMG_W_DEF,
    parameter int IMG_H  = IMG_H_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              wr_en,
    input  logic [$clog2(IMG_W*IMG_H)-1:0]    wr_addr,
    input  logic [DATA_W-1:0]                 wr_data,
    input  logic                              start,
    output logic [DATA_W-1:0]                 d_out,
    output logic                              d_valid,
    input  logic                              d_ready,
    output logic                              sof,
    output logic                              eol,
    output logic                              eof,
    output logic                              busy,
    output logic                              done
`ifdef PIXEL_FEEDER_TESTPAT_EN
    ,
    input  logic                              test_mode
`endif
);

    localparam int NPIX = IMG_W * IMG_H;
    localparam int AW   = $clog2(NPIX);
    localparam int CW   = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int RW   = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam logic [AW-1:0] LAST_ADDR = AW'(NPIX - 1);
    localparam logic [CW-1:0] COL_LAST  = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST  = RW'(IMG_H - 1);

    feeder_state_e     state_q;
    logic              busy_q, done_q;
    logic [AW-1:0]     rd_addr_q;
    logic              rd_left_q, rd_pend_q;
    logic [DATA_W-1:0] d_out_q, d_out_d, skid_q, skid_d;
    logic              d_valid_q, d_valid_d, skid_v_q, skid_v_d;
    logic [CW-1:0]     col_q, col_d;
    logic [RW-1:0]     row_q, row_d;
    logic              sof_q, sof_d, eol_q, eol_d, eof_q, eof_d;

    logic              start_s, we_s, pop_s, rd_issue_s;
    logic [1:0]        occ_s;
    logic [DATA_W-1:0] ram_rdata_s, in_data_s;

    assign start_s = (state_q == ST_IDLE) && start;
    assign we_s    = (state_q == ST_IDLE) && wr_en;
    assign pop_s   = d_valid_q && d_ready;
    assign occ_s   = {1'b0, d_valid_q} + {1'b0, skid_v_q} + {1'b0, rd_pend_q};
    // Credit check: head + skid + in-flight read never exceed the two slots.
    assign rd_issue_s = ((state_q == ST_FETCH) || (state_q == ST_STREAM)) && rd_left_q &&
                        ((occ_s < 2'd2) || ((occ_s == 2'd2) && pop_s));

    feeder_frame_ram #(
        .DEPTH (NPIX),
        .AW    (AW),
        .DW    (DATA_W)
    ) u_ram (
        .clk     (clk),
        .we_i    (we_s),
        .waddr_i (wr_addr),
        .wdata_i (wr_data),
        .re_i    (rd_issue_s),
        .raddr_i (rd_addr_q),
        .rdata_o (ram_rdata_s)
    );

`ifdef PIXEL_FEEDER_TESTPAT_EN
    logic       test_q;
    logic [2:0] pat_cnt_q, pat_in_q;

    // Pattern value rides alongside the read request so it lines up with RAM latency.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            test_q    <= 1'b0;
            pat_cnt_q <= PAT_FIRST;
            pat_in_q  <= PAT_FIRST;
        end else if (start_s) begin
            test_q    <= test_mode;
            pat_cnt_q <= PAT_FIRST;
            pat_in_q  <= pat_in_q;
        end else if (rd_issue_s) begin
            test_q    <= test_q;
            pat_cnt_q <= next_pat(pat_cnt_q);
            pat_in_q  <= pat_cnt_q;
        end else begin
            test_q    <= test_q;
            pat_cnt_q <= pat_cnt_q;
            pat_in_q  <= pat_in_q;
        end
    end

    // Select the pixel source for this frame.
    always_comb begin
        if (test_q) begin
            in_data_s = DATA_W'(pat_in_q);
        end else begin
            in_data_s = ram_rdata_s;
        end
    end
`else
    assign in_data_s = ram_rdata_s;
`endif

    // Two-slot skid: d_out_q is the head, skid_q catches a read landing during a stall.
    always_comb begin
        d_out_d   = d_out_q;
        d_valid_d = d_valid_q;
        skid_d    = skid_q;
        skid_v_d  = skid_v_q;
        if (pop_s) begin
            if (skid_v_q) begin
                d_out_d = skid_q;
                if (rd_pend_q) begin
                    skid_d = in_data_s;
                end else begin
                    skid_v_d = 1'b0;
                end
            end else if (rd_pend_q) begin
                d_out_d = in_data_s;
            end else begin
                d_valid_d = 1'b0;
            end
        end else if (rd_pend_q) begin
            if (!d_valid_q) begin
                d_out_d   = in_data_s;
                d_valid_d = 1'b1;
            end else begin
                skid_d   = in_data_s;
                skid_v_d = 1'b1;
            end
        end else begin
            d_valid_d = d_valid_q;
        end
    end

    // col/row track the pixel at the head; flags are precomputed for the next head.
    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (start_s) begin
            col_d = {CW{1'b0}};
            row_d = {RW{1'b0}};
        end else if (pop_s) begin
            if (col_q == COL_LAST) begin
                col_d = {CW{1'b0}};
                if (row_q == ROW_LAST) begin
                    row_d = {RW{1'b0}};
                end else begin
                    row_d = row_q + RW'(1);
                end
            end else begin
                col_d = col_q + CW'(1);
            end
        end else begin
            col_d = col_q;
        end
        eol_d = d_valid_d && (col_d == COL_LAST);
        eof_d = eol_d && (row_d == ROW_LAST);
        sof_d = d_valid_d && (col_d == {CW{1'b0}}) && (row_d == {RW{1'b0}});
    end

    // Frame control FSM with registered busy/done.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_q <= ST_FETCH;
                        busy_q  <= 1'b1;
                    end
                end
                ST_FETCH: begin
                    state_q <= ST_STREAM;
                end
                ST_STREAM: begin
                    if (pop_s && eof_q) begin
                        state_q <= ST_DONE;
                        done_q  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    // Read address generation, skid storage, position counters and output flags.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_addr_q <= {AW{1'b0}};
            rd_left_q <= 1'b0;
            rd_pend_q <= 1'b0;
            d_out_q   <= {DATA_W{1'b0}};
            d_valid_q <= 1'b0;
            skid_q    <= {DATA_W{1'b0}};
            skid_v_q  <= 1'b0;
            col_q     <= {CW{1'b0}};
            row_q     <= {RW{1'b0}};
            sof_q     <= 1'b0;
            eol_q     <= 1'b0;
            eof_q     <= 1'b0;
        end else begin
            rd_pend_q <= rd_issue_s;
            if (start_s) begin
                rd_addr_q <= {AW{1'b0}};
                rd_left_q <= 1'b1;
            end else if (rd_issue_s) begin
                rd_addr_q <= rd_addr_q + AW'(1);
                rd_left_q <= (rd_addr_q != LAST_ADDR);
            end else begin
                rd_addr_q <= rd_addr_q;
                rd_left_q <= rd_left_q;
            end
            d_out_q   <= d_out_d;
            d_valid_q <= d_valid_d;
            skid_q    <= skid_d;
            skid_v_q  <= skid_v_d;
            col_q     <= col_d;
            row_q     <= row_d;
            sof_q     <= sof_d;
            eol_q     <= eol_d;
            eof_q     <= eof_d;
        end
    end

    assign d_out   = d_out_q;
    assign d_valid = d_valid_q;
    assign sof     = sof_q;
    assign eol     = eol_q;
    assign eof     = eof_q;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule

// File: tb/tb_pixel_feeder.sv
// Directed + randomized bench for pixel_feeder on a 4x3 frame, checked against
// a raster-order reference built from a model of the frame buffer.
module tb_pixel_feeder;

    localparam int W  = 4;
    localparam int H  = 3;
    localparam int N  = W * H;
    localparam int DW = 8;
    localparam int AW = 4;

    logic          clk     = 1'b0;
    logic          rst     = 1'b0;
    logic          wr_en   = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [DW-1:0] wr_data = '0;
    logic          start   = 1'b0;
    logic          d_ready = 1'b0;
`ifdef PIXEL_FEEDER_TESTPAT_EN
    logic          test_mode = 1'b0;
`endif
    logic [DW-1:0] d_out;
    logic          d_valid, sof, eol, eof, busy, done;

    int n_assert = 0;
    int n_fail   = 0;

    logic [DW-1:0] model_mem [N];
    logic [DW-1:0] exp_pix   [N];

    always #5 clk = ~clk;

    pixel_feeder #(.IMG_W(W), .IMG_H(H), .DATA_W(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .start     (start),
        .d_out     (d_out),
        .d_valid   (d_valid),
        .d_ready   (d_ready),
        .sof       (sof),
        .eol       (eol),
        .eof       (eof),
        .busy      (busy),
        .done      (done)
`ifdef PIXEL_FEEDER_TESTPAT_EN
        ,
        .test_mode (test_mode)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_d_out"},   32'(d_out),   32'd0);
        check({tag, "_d_valid"}, 32'(d_valid), 32'd0);
        check({tag, "_sof"},     32'(sof),     32'd0);
        check({tag, "_eol"},     32'(eol),     32'd0);
        check({tag, "_eof"},     32'(eof),     32'd0);
        check({tag, "_busy"},    32'(busy),    32'd0);
        check({tag, "_done"},    32'(done),    32'd0);
    endtask

    task automatic load_mem();
        for (int i = 0; i < N; i++) begin
            @(negedge clk);
            wr_en   = 1'b1;
            wr_addr = AW'(i);
            wr_data = model_mem[i];
        end
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    // mode: 0 ready held high, 1 ready toggles 1,0,..., 2 random ready.
    task automatic run_frame(input int mode, input int abort_at, input bit inject,
                             input bit ws, input logic [DW-1:0] ws_val, input bit use_pat);
        int idx;
        bit tog;
        bit rdy;
        bit injected;
        bit aborted;
        idx = 0; tog = 1'b1; injected = 1'b0; aborted = 1'b0;
        if (ws) model_mem[0] = ws_val;
        for (int i = 0; i < N; i++) begin
            if (use_pat) exp_pix[i] = DW'((i % 5) + 1);
            else         exp_pix[i] = model_mem[i];
        end
        @(negedge clk);
        start = 1'b1;
        if (ws) begin
            wr_en = 1'b1; wr_addr = '0; wr_data = ws_val;
        end
        @(negedge clk);
        start = 1'b0; wr_en = 1'b0;
        check("busy_after_start", 32'(busy), 32'd1);
        check("valid_early_1", 32'(d_valid), 32'd0);
        @(negedge clk);
        check("valid_early_2", 32'(d_valid), 32'd0);
        for (int cyc = 0; cyc < 200 && idx < N && !aborted; cyc++) begin
            @(negedge clk);
            start = 1'b0; wr_en = 1'b0;
            if (cyc == 0) check("first_valid", 32'(d_valid), 32'd1);
            case (mode)
                1:       begin rdy = tog; tog = ~tog; end
                2:       rdy = 1'($urandom_range(0, 1));
                default: rdy = 1'b1;
            endcase
            d_ready = rdy;
            if (inject && !injected && idx == 3) begin
                start = 1'b1; wr_en = 1'b1; wr_addr = '0; wr_data = 8'd99;
                injected = 1'b1;
            end
            if (d_valid) begin
                check("pix",  32'(d_out), 32'(exp_pix[idx]));
                check("sof",  32'(sof),   32'(idx == 0));
                check("eol",  32'(eol),   32'((idx % W) == W - 1));
                check("eof",  32'(eof),   32'(idx == N - 1));
                check("busy_in_frame", 32'(busy), 32'd1);
                if (rdy) idx++;
            end else if (mode == 0 && cyc > 0) begin
                check("bubble", 32'(d_valid), 32'd1);
            end
            if (abort_at > 0 && idx == abort_at) begin
                @(posedge clk);
                #1 rst = 1'b0;
                #1;
                check_zero("abort");
                aborted = 1'b1;
            end
        end
        start = 1'b0; wr_en = 1'b0;
        if (!aborted) begin
            check("transfers", 32'(idx), 32'(N));
            @(negedge clk);
            check("done_pulse", 32'(done), 32'd1);
            check("valid_after_eof", 32'(d_valid), 32'd0);
            @(negedge clk);
            check("done_drop", 32'(done), 32'd0);
            check("busy_drop", 32'(busy), 32'd0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1);
    end

    initial begin
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check_zero("reset");
        rst = 1'b1;
        @(negedge clk);
        check_zero("idle");

        for (int i = 0; i < N; i++) model_mem[i] = DW'(10 + i);
        load_mem();

        run_frame(0, 0, 1'b0, 1'b0, 8'd0, 1'b0);
        run_frame(1, 0, 1'b0, 1'b0, 8'd0, 1'b0);

        run_frame(0, 5, 1'b0, 1'b0, 8'd0, 1'b0);
        repeat (3) begin
            @(negedge clk);
            check("no_done_in_reset", 32'(done), 32'd0);
            check("no_busy_in_reset", 32'(busy), 32'd0);
        end
        rst = 1'b1;
        @(negedge clk);
        check("no_done_after_abort", 32'(done), 32'd0);
        run_frame(0, 0, 1'b0, 1'b0, 8'd0, 1'b0);

        run_frame(0, 0, 1'b1, 1'b0, 8'd0, 1'b0);
        run_frame(0, 0, 1'b0, 1'b0, 8'd0, 1'b0);

        run_frame(2, 0, 1'b0, 1'b1, 8'd55, 1'b0);

        for (int f = 0; f < 3; f++) begin
            for (int i = 0; i < N; i++) model_mem[i] = DW'($urandom_range(0, 255));
            load_mem();
            run_frame(2, 0, 1'b0, 1'b0, 8'd0, 1'b0);
        end

`ifdef PIXEL_FEEDER_TESTPAT_EN
        test_mode = 1'b1;
        run_frame(0, 0, 1'b0, 1'b0, 8'd0, 1'b1);
        run_frame(2, 0, 1'b0, 1'b0, 8'd0, 1'b1);
        test_mode = 1'b0;
        run_frame(0, 0, 1'b0, 1'b0, 8'd0, 1'b0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/pixel_feeder.md
PIXEL_FEEDER -- requirements
Module: pixel_feeder

Interface
REQ-001 Parameter IMG_W, default 28, pixels per line.
REQ-002 Parameter IMG_H, default 28, lines per frame.
REQ-003 Parameter DATA_W, default 8, pixel width.
REQ-004 Port clk, input, 1: single clock, all logic on its rising edge.
REQ-005 Port rst, input, 1: reset, asynchronous, active-low.
REQ-006 Port wr_en, input, 1: frame-buffer write strobe.
REQ-007 Port wr_addr, input, clog2(IMG_W*IMG_H): raster write address.
REQ-008 Port wr_data, input, DATA_W: pixel written.
REQ-009 Port start, input, 1: one-cycle pulse that begins a frame.
REQ-010 Port d_out, output, DATA_W: streamed pixel, width-compatible with the convolution top's d_in.
REQ-011 Port d_valid, output, 1: d_out holds a pixel.
REQ-012 Port d_ready, input, 1: consumer accepts the pixel.
REQ-013 Port sof / eol / eof, output, 1 each: first pixel of frame / last of line / last of frame, qualified by d_valid.
REQ-014 Port busy, output, 1: frame in progress.
REQ-015 Port done, output, 1: one-cycle pulse after the eof transfer.

Function
REQ-016 FSM states: IDLE, FETCH, STREAM, DONE.
- IDLE->FETCH on start.
- FETCH->STREAM after one cycle.
- STREAM->DONE on the eof transfer.
- DONE->IDLE unconditionally.
REQ-017 A transfer occurs when d_valid && d_ready on a rising edge.
REQ-018 Frame-buffer read latency is 1 cycle; a 2-entry skid/prefetch stage is required.
REQ-019 First d_valid asserts exactly 2 cycles after the start pulse.
REQ-020 Throughput: with d_ready held high, one pixel per cycle, no bubbles.
REQ-021 While d_valid && !d_ready, d_out, sof, eol and eof hold stable.
REQ-022 Pixels emit in raster order, address 0 .. IMG_W*IMG_H-1.
REQ-023 Column counter wraps IMG_W-1->0 and increments the row counter on that transfer.
REQ-024 eol asserts when col==IMG_W-1; eof when additionally row==IMG_H-1.
REQ-025 start while busy is ignored.
REQ-026 wr_en while busy is ignored, so the frame stays coherent.
REQ-027 wr_en && start in the same cycle in IDLE: the write completes and the frame starts, with the written pixel visible.
REQ-028 busy is high in FETCH, STREAM and DONE; done is high only in DONE.
REQ-029 Counters are unsigned; no arithmetic beyond increment and compare.

Reset
REQ-030 On rst low: FSM to IDLE; counters 0; d_valid, sof, eol, eof, busy, done all 0; d_out 0.
REQ-031 Reset mid-frame aborts the frame immediately, with no done pulse.
REQ-032 Frame-buffer contents are not reset.

Configuration
REQ-033 Macro PIXEL_FEEDER_TESTPAT_EN.
REQ-034 When the macro is defined:
- Add an input test_mode, 1 bit.
- When test_mode is high at start, the frame streams the repeating sequence 1,2,3,4,5,1,... starting at 1, in place of buffer data.
- Timing and flags are identical to buffer mode.
REQ-035 When the macro is undefined, no test_mode port exists and the pattern logic is absent.

Structure
REQ-036 A shared package holds:
- the FSM state typedef;
- the default IMG_W, IMG_H and DATA_W constants, shared with the convolution top.
REQ-037 One sub-module, feeder_frame_ram: single-port-write / single-port-read synchronous RAM with 1-cycle read latency.

Verification (bench uses IMG_W=4, IMG_H=3)
REQ-038 Load addresses 0..11 with values 10..21, pulse start, hold d_ready=1:
- d_valid rises 2 cycles later;
- 12 consecutive transfers of 10..21;
- sof on 10; eol on 13, 17 and 21; eof on 21;
- done is pulsed 1 cycle after the eof transfer.
REQ-039 Same load, d_ready toggled 1,0,1,0: each pixel is held across its stall cycle, values remain in order, and 12 transfers occur in total.
REQ-040 Assert rst low after the 5th transfer: all outputs are 0 the same cycle and no done pulse follows. After release, start restreams from 10.
REQ-041 start pulsed again mid-frame, plus wr_en to address 0 with value 99: the frame is unaffected, and the next frame starts with 10.
REQ-042 With PIXEL_FEEDER_TESTPAT_EN defined, test_mode=1, start: the stream is 1,2,3,4,5,1,2,3,4,5,1,2 with eof on the final 2.
